nn_mem_arbiter: RTL
===================

Name: nn_mem_arbiter

Overview:
Shares the single-port SoC RAM word array between several requesters: debug loader, CPU load/store, and CPU instruction fetch. Each cycle it grants at most one request, using round-robin arbitration with an optional bounded lock for multi-word bursts. It drives the RAM port and routes synchronous read data back to the requester that issued the read. It sits between the CPU core and the RAM; losing requesters see gnt low and stall.

Parameters:
N_REQ, 3, number of requesters (index 0 = debug, 1 = data, 2 = ifetch)
AW, 10, RAM word-address width (1024 words)
DW, 32, data width
MAX_LOCK, 4, max consecutive grants one locked owner may hold while others wait

Ports:
CLK  in  1  clock; all state updates on posedge
RST_N  in  1  synchronous active-low reset, sampled on posedge CLK
req  in  N_REQ  per-requester access request
we  in  N_REQ  per-requester write enable (1 = store, 0 = load)
lock  in  N_REQ  requester asks to keep grant on its next request
addr  in  N_REQ*32  byte addresses, packed, requester i at [32*i+:32]
wdata  in  N_REQ*DW  write data, packed
gnt  out  N_REQ  one-hot grant, combinational, same cycle as req
rvalid  out  N_REQ  one-hot read-data-valid, registered
rdata  out  DW  read data, shared, valid where rvalid set
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write strobe
ram_addr  out  AW  RAM word address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, registered inside RAM, 1-cycle latency

Behaviour:
- Reset (RST_N=0 at posedge):
  - last_owner=N_REQ-1, lock_cnt=0, rsp_valid=0, rvalid=0, out_of_range flag=0.
  - Combinational outputs are forced low while RST_N=0: gnt=0, ram_en=0, ram_we=0.
  - Reset mid-operation drops any pending rvalid; no response is delivered after reset.
- Transfer: a transfer occurs on posedge when req[i]&gnt[i]. Requesters must hold req/we/addr/wdata stable until granted.
- Arbitration (combinational), order of checks:
  - (a) Retention: if owner = last_owner, and req[owner]&lock[owner] were set on the previous accepted transfer, and req[owner] is high now, and (lock_cnt<MAX_LOCK-1 or no other req pending): owner keeps the grant.
  - (b) Otherwise: round-robin scan from last_owner+1 (mod N_REQ); the first req found wins.
  - (c) No req: gnt=0, ram_en=0.
- State on each accepted transfer:
  - last_owner <= winner.
  - lock_cnt <= retained ? sat(lock_cnt+1, MAX_LOCK-1) : 0.
- RAM drive:
  - ram_addr=addr[winner][AW+1:2]; ram_we=we[winner]; ram_wdata=wdata[winner].
  - ram_en=|gnt only when addr[winner][31:AW+2]==0.
  - An out-of-range access is still granted (requester must not hang): writes are discarded, reads return 0.
  - addr[1:0] is ignored; all accesses are whole words.
- Read response:
  - An accepted read registers rsp_id=winner and the range flag.
  - Next cycle: rvalid[rsp_id]=1 and rdata=ram_rdata (or 0 if out of range).
  - Writes produce no rvalid.
- Back-to-back: a new grant may be issued in the same cycle as rvalid of the previous read, giving full throughput of one access per cycle.
- Lock rules:
  - lock is ignored on cycles the requester is not granted.
  - Deasserting lock or req ends retention. The next arbitration is round-robin from that owner, so the owner goes to the lowest priority.
- Simultaneous reqs on all three requesters from reset: grants go 0,1,2,0,... one per cycle.

Decomposition:
- Package nn_mem_pkg:
  - REQ_DBG=0, REQ_DATA=1, REQ_IFETCH=2
  - RAM_AW=10, DW=32
  - MAX_LOCK default
  - req_id_t = logic [1:0]
- Sub-module nn_rr_pick: pure combinational round-robin picker. Inputs req vector and last index; outputs one-hot grant and winner index. Reused later for register-file port sharing.

Test Plan:
- Reset, then req=3'b111 all reads to 0x0,0x4,0x8 held -> gnt 001,010,100,001 on consecutive cycles; rvalid one cycle after each grant with matching RAM words.
- Requester 1 write 0xDEADBEEF to 0x10, next cycle requester 2 read 0x10 -> rvalid[2]=1 with rdata=0xDEADBEEF, no rvalid[1].
- Requester 0 req+lock continuously with req[2]=1 -> gnt[0] for exactly 4 cycles (MAX_LOCK), then gnt[2] one cycle, then back to 0. With req[2]=0, gnt[0] holds indefinitely.
- Read addr 0x00001000 (out of range) -> granted, ram_en=0, next cycle rvalid=1, rdata=0. Write out of range -> RAM contents unchanged.
- Read granted, RST_N=0 on the next posedge -> rvalid stays 0. After release, last_owner=2, so requester 0 wins first.
- Random req/we/lock for 10k cycles vs. reference model -> gnt always one-hot or zero; every accepted read gets exactly one rvalid; no requester waits more than (N_REQ-1)*MAX_LOCK cycles.

Source files
------------

// File: rtl/nn_mem_pkg.sv
// Shared definitions for the SoC RAM arbiter and its round-robin picker.
// Requester indices double as grant and response-routing identifiers.
package nn_mem_pkg;

  localparam int REQ_DBG    = 0;
  localparam int REQ_DATA   = 1;
  localparam int REQ_IFETCH = 2;

  localparam int RAM_AW   = 10;
  localparam int DW       = 32;
  localparam int MAX_LOCK = 4;

  typedef logic [1:0] req_id_t;

endpackage

// File: rtl/nn_rr_pick.sv
// Combinational round-robin picker: first request after last_i wins, 0-cycle latency.
// No backpressure; at most 4 requesters because indices are req_id_t wide.
module nn_rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   last_i,
  output logic [N-1:0] gnt_o,
  output logic [1:0]   idx_o,
  output logic         vld_o
);
  import nn_mem_pkg::*;

  req_id_t cand;

  // Scan farthest-to-nearest so the requester right after last_i overwrites the rest.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = req_id_t'((int'(last_i) + k) % N);
      if (req_i[cand]) begin
        idx_o = cand;
        vld_o = 1'b1;
      end
    end
    if (vld_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/nn_mem_arbiter.sv
// Single-port RAM arbiter: same-cycle grant, read data routed back one cycle later.
// Losers see gnt low and must hold their request; locked owners yield after MAX_LOCK grants.
module nn_mem_arbiter #(
  parameter int N_REQ    = 3,
  parameter int AW       = nn_mem_pkg::RAM_AW,
  parameter int DW       = nn_mem_pkg::DW,
  parameter int MAX_LOCK = nn_mem_pkg::MAX_LOCK
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    we,
  input  logic [N_REQ-1:0]    lock,
  input  logic [N_REQ*32-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_wdata,
  input  logic [DW-1:0]       ram_rdata
);
  import nn_mem_pkg::*;

  localparam int LCW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [LCW-1:0] CNT_MAX = LCW'(MAX_LOCK - 1);

  req_id_t          last_owner_q;
  req_id_t          rsp_id_q;
  req_id_t          rr_idx;
  req_id_t          win;
  logic [LCW-1:0]   lock_cnt_q;
  logic [LCW-1:0]   lock_cnt_d;
  logic             locked_q;
  logic             rsp_vld_q;
  logic             rsp_oor_q;
  logic [N_REQ-1:0] rr_gnt;
  logic [N_REQ-1:0] own_mask;
  logic [N_REQ-1:0] gnt_raw;
  logic             rr_vld;
  logic             other_req;
  logic             retain;
  logic             xfer;
  logic             in_range;
  logic [31:0]      win_addr;

  nn_rr_pick #(.N(N_REQ)) u_pick (
    .req_i  (req),
    .last_i (last_owner_q),
    .gnt_o  (rr_gnt),
    .idx_o  (rr_idx),
    .vld_o  (rr_vld)
  );

  assign own_mask  = N_REQ'(1) << last_owner_q;
  assign other_req = |(req & ~own_mask);

  // The lock counter only caps retention when someone else is actually waiting.
  assign retain  = locked_q && req[last_owner_q] && ((lock_cnt_q != CNT_MAX) || !other_req);
  assign win     = retain ? last_owner_q : rr_idx;
  assign gnt_raw = retain ? own_mask : (rr_vld ? rr_gnt : '0);
  assign gnt     = RST_N ? gnt_raw : '0;
  assign xfer    = |gnt;

  assign win_addr  = addr[32*win +: 32];
  assign in_range  = (win_addr[31:AW+2] == '0);
  assign ram_en    = xfer && in_range;
  assign ram_we    = ram_en && we[win];
  assign ram_addr  = win_addr[AW+1:2];
  assign ram_wdata = wdata[DW*win +: DW];

  assign lock_cnt_d = !retain                ? '0 :
                      (lock_cnt_q == CNT_MAX) ? lock_cnt_q :
                                                lock_cnt_q + LCW'(1);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_owner_q <= req_id_t'(N_REQ - 1);
      lock_cnt_q   <= '0;
      locked_q     <= 1'b0;
      rsp_vld_q    <= 1'b0;
      rsp_id_q     <= '0;
      rsp_oor_q    <= 1'b0;
    end else begin
      rsp_vld_q <= xfer && !we[win];
      if (xfer) begin
        last_owner_q <= win;
        lock_cnt_q   <= lock_cnt_d;
        locked_q     <= lock[win];
        rsp_id_q     <= win;
        rsp_oor_q    <= !in_range;
      end
    end
  end

  // Out-of-range reads still complete, but with zero data.
  assign rvalid = rsp_vld_q ? (N_REQ'(1) << rsp_id_q) : '0;
  assign rdata  = (rsp_vld_q && !rsp_oor_q) ? ram_rdata : '0;

endmodule
